// File: rtl/rc4_pkg.sv
// Shared types and default constants for the RC4 keystream consumer.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [0:0] {
    F_WAIT,
    F_BLANK
  } fetch_state_e;

  localparam int unsigned KS_DEPTH_DEF = 4;
  localparam int unsigned DROP_N_DEF   = 256;
  localparam int unsigned CNT_W_DEF    = 32;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream prefetch FIFO with show-ahead head output; DEPTH must be a power of two.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int unsigned DEPTH = KS_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  byte_t                    push_data,
  input  logic                     pop,
  output byte_t                    head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
        level_q <= level_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rc4_xor_stream.sv
// XORs a valid/ready byte stream with prefetched RC4 keystream bytes.
// Define RC4_DROP_EN to discard the first DROP_N keystream bytes after reset (RC4-drop[N]).
module rc4_xor_stream
  import rc4_pkg::*;
#(
  parameter int unsigned KS_DEPTH = KS_DEPTH_DEF,
  parameter int unsigned DROP_N   = DROP_N_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ks_valid,
  input  logic [7:0]                ks_data,
  output logic                      ks_next,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic                      out_last,
  output logic [CNT_W-1:0]          byte_cnt,
  output logic [$clog2(KS_DEPTH):0] ks_level
);

  fetch_state_e     state_q;
  logic             ks_next_q;
  logic             out_valid_q, out_last_q;
  byte_t            out_data_q;
  logic [CNT_W-1:0] byte_cnt_q;

  logic  capture, push, accept;
  logic  fifo_full, fifo_empty;
  byte_t fifo_head;

  assign capture  = (state_q == F_WAIT) && ks_valid && !fifo_full;
  assign in_ready = !fifo_empty && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // The generator keeps key_valid high one cycle past nxt_key, so F_BLANK waits
  // for it to drop before allowing the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= F_WAIT;
      ks_next_q <= 1'b0;
    end else begin
      case (state_q)
        F_WAIT: begin
          if (capture) begin
            ks_next_q <= 1'b1;
            state_q   <= F_BLANK;
          end
        end
        F_BLANK: begin
          ks_next_q <= 1'b0;
          if (!ks_valid) state_q <= F_WAIT;
        end
        default: begin
          ks_next_q <= 1'b0;
          state_q   <= F_WAIT;
        end
      endcase
    end
  end

`ifdef RC4_DROP_EN
  localparam int unsigned DW = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;

  logic [DW-1:0] drop_cnt_q;
  logic          dropping;

  assign dropping = (drop_cnt_q < DW'(DROP_N));
  assign push     = capture && !dropping;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (capture && dropping) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end
`else
  logic unused_drop_n;

  assign unused_drop_n = |DROP_N;
  assign push          = capture;
`endif

  rc4_ks_fifo #(
    .DEPTH (KS_DEPTH)
  ) u_ks_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ks_data),
    .pop       (accept),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (ks_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      byte_cnt_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data ^ fifo_head;
      out_last_q  <= in_last;
      byte_cnt_q  <= byte_cnt_q + 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign ks_next   = ks_next_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Self-checking bench for rc4_xor_stream with a stub keystream generator and a stream model.
module tb_rc4_xor_stream;

  localparam int KS_DEPTH = 4;
`ifdef RC4_DROP_EN
  localparam int DROP = 3;
`else
  localparam int DROP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ks_valid = 1'b0;
  logic [7:0]  ks_data = 8'h00;
  logic        ks_next;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic [31:0] byte_cnt;
  logic [2:0]  ks_level;

  always #5 clk = ~clk;

  rc4_xor_stream #(
    .KS_DEPTH (KS_DEPTH),
    .DROP_N   (3),
    .CNT_W    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ks_valid  (ks_valid),
    .ks_data   (ks_data),
    .ks_next   (ks_next),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .byte_cnt  (byte_cnt),
    .ks_level  (ks_level)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Stub generator: byte g_idx is offered; after each nxt_key it advances, keeps
  // key_valid high one more cycle (showing the next byte), then gaps 1..4 cycles.
  logic [7:0] ks_arr [4096];
  int g_idx = 0, g_gap = 0, g_pulses = 0, g_err = 0;
  bit g_hold = 0, g_prev = 0, gen_en = 0;

  initial begin
    for (int i = 0; i < 4096; i++) ks_arr[i] = 8'($urandom);
  end

  initial forever begin
    @(negedge clk);
    if (ks_next && (g_prev || !ks_valid)) g_err++;
    g_prev = ks_next;
    if (g_hold) begin
      ks_valid = 1'b0;
      g_hold   = 0;
      g_gap    = $urandom_range(3, 0);
    end else if (ks_next) begin
      g_pulses++;
      g_idx++;
      g_hold = 1;
    end else if (!ks_valid && gen_en && g_idx < 4000) begin
      if (g_gap == 0) ks_valid = 1'b1;
      else g_gap--;
    end
    ks_data = ks_arr[g_idx];
  end

  // Stream model: the k-th accepted byte since reset pairs with keystream byte base+DROP+k.
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int acc_n = 0, base = 0, p_base = 0;

  initial forever begin
    @(negedge clk);
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back({in_last, in_data ^ ks_arr[base + DROP + acc_n]});
      acc_n++;
    end
    if (!rst && out_valid && out_ready) got_q.push_back({out_last, out_data});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 50 && (g_hold || ks_next); i++) tick();
    n_chk++;
    if (g_hold || ks_next) $display("FAIL reset_quiesce: generator still busy got %0d want 0", g_hold);
    else n_pass++;
    rst    = 1'b1;
    base   = g_idx;
    p_base = g_pulses;
    tick();
    rst   = 1'b0;
    acc_n = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h want 00", out_data); else n_pass++;
    n_chk++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last); else n_pass++;
    n_chk++; if (byte_cnt !== 32'd0) $display("FAIL rst_byte_cnt: got %0d want 0", byte_cnt); else n_pass++;
    n_chk++; if (ks_level !== 3'd0) $display("FAIL rst_ks_level: got %0d want 0", ks_level); else n_pass++;
    n_chk++; if (ks_next !== 1'b0) $display("FAIL rst_ks_next: got %b want 0", ks_next); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
  endtask

  task automatic test_known();
    logic [8:0] g0, g1;
    ks_arr[base + DROP]     = 8'hA5;
    ks_arr[base + DROP + 1] = 8'h3C;
    gen_en = 1;
    for (int i = 0; i < 400 && ks_level < 3'd2; i++) tick();
    gen_en    = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_last   = 1'b0;
    tick();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL known_latency_valid: got %b want 1", out_valid); else n_pass++;
    n_chk++; if (out_data !== 8'h5A) $display("FAIL known_latency_data: got %h want 5a", out_data); else n_pass++;
    in_data = 8'h00;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    g0 = (got_q.size() > 0) ? got_q[0] : 9'h1FF;
    g1 = (got_q.size() > 1) ? got_q[1] : 9'h1FF;
    n_chk++; if (g0 !== 9'h05A) $display("FAIL known_byte0: got %h want 05a", g0); else n_pass++;
    n_chk++; if (g1 !== 9'h13C) $display("FAIL known_byte1: got %h want 13c", g1); else n_pass++;
    n_chk++; if (byte_cnt !== 32'd2) $display("FAIL known_byte_cnt: got %0d want 2", byte_cnt); else n_pass++;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_fill();
    int extra, tgt;
    do_reset();
    gen_en = 1;
    for (int i = 0; i < 400 && ks_level < 3'(KS_DEPTH); i++) tick();
    extra = 0;
    repeat (30) begin
      tick();
      if (ks_next) extra++;
    end
    n_chk++; if (ks_level !== 3'(KS_DEPTH)) $display("FAIL fill_level: got %0d want %0d", ks_level, KS_DEPTH); else n_pass++;
    n_chk++; if (extra !== 0) $display("FAIL fill_no_fetch_when_full: got %0d pulses want 0", extra); else n_pass++;
    n_chk++;
    if (g_pulses - p_base !== KS_DEPTH + DROP)
      $display("FAIL fill_pulses: got %0d want %0d", g_pulses - p_base, KS_DEPTH + DROP);
    else n_pass++;
    n_chk++; if (g_err !== 0) $display("FAIL fill_handshake: got %0d bad pulses want 0", g_err); else n_pass++;
    tgt = acc_n + 4;
    out_ready = 1'b1;
    for (int i = 0; i < 400 && acc_n < tgt; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    n_chk++; if (got_q.size() !== 4) $display("FAIL fill_drain_count: got %0d want 4", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) $display("FAIL fill_drain[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int tgt;
    gen_en = 1;
    for (int i = 0; i < 400 && ks_level < 3'd2; i++) tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    tick();
    held = exp_q[$][7:0];
    for (int c = 0; c < 5; c++) begin
      in_data = 8'($urandom);
      n_chk++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); else n_pass++;
      n_chk++; if (out_data !== held) $display("FAIL bp_data[%0d]: got %h want %h", c, out_data, held); else n_pass++;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    tgt = acc_n + 3;
    for (int i = 0; i < 400 && acc_n < tgt; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (got_q.size() !== exp_q.size()) $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) $display("FAIL bp_stream[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_stream();
    gen_en = 1;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(9, 0) < 7);
      out_ready = ($urandom_range(9, 0) < 6);
      in_data   = 8'($urandom);
      in_last   = 1'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    n_chk++; if (acc_n < 20) $display("FAIL stream_progress: got %0d bytes want >=20", acc_n); else n_pass++;
    n_chk++;
    if (got_q.size() !== exp_q.size()) $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) $display("FAIL stream[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_chk++; if (byte_cnt !== 32'(acc_n)) $display("FAIL stream_byte_cnt: got %0d want %0d", byte_cnt, acc_n); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL stream_idle: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (g_err !== 0) $display("FAIL stream_handshake: got %0d bad pulses want 0", g_err); else n_pass++;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    int tgt;
    gen_en = 1;
    for (int i = 0; i < 400 && ks_level < 3'd3; i++) tick();
    gen_en    = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", out_valid); else n_pass++;
    n_chk++; if (ks_level < 3'd2) $display("FAIL mid_pre_level: got %0d want >=2", ks_level); else n_pass++;
    do_reset();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (ks_level !== 3'd0) $display("FAIL mid_ks_level: got %0d want 0", ks_level); else n_pass++;
    n_chk++; if (byte_cnt !== 32'd0) $display("FAIL mid_byte_cnt: got %0d want 0", byte_cnt); else n_pass++;
    n_chk++; if (ks_next !== 1'b0) $display("FAIL mid_ks_next: got %b want 0", ks_next); else n_pass++;
    gen_en    = 1;
    out_ready = 1'b1;
    tgt = 3;
    for (int i = 0; i < 400 && acc_n < tgt; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    n_chk++; if (got_q.size() !== 3) $display("FAIL mid_resume_count: got %0d want 3", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) $display("FAIL mid_resume[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

`ifdef RC4_DROP_EN
  task automatic test_drop();
    logic [8:0] g0;
    gen_en = 0;
    do_reset();
    for (int i = 0; i < 5; i++) ks_arr[base + i] = 8'(i + 1);
    gen_en = 1;
    for (int i = 0; i < 400 && g_pulses - p_base < 5; i++) tick();
    gen_en = 0;
    repeat (20) tick();
    n_chk++; if (g_pulses - p_base !== 5) $display("FAIL drop_pulses: got %0d want 5", g_pulses - p_base); else n_pass++;
    n_chk++; if (ks_level !== 3'd2) $display("FAIL drop_level: got %0d want 2", ks_level); else n_pass++;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    in_last   = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    g0 = (got_q.size() > 0) ? got_q[0] : 9'h1FF;
    n_chk++; if (g0 !== 9'h004) $display("FAIL drop_first_byte: got %h want 004", g0); else n_pass++;
    exp_q.delete();
    got_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_known();
    test_fill();
    test_backpressure();
    test_stream();
    test_reset_mid();
`ifdef RC4_DROP_EN
    test_drop();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rc4_xor_stream.md
# rc4_xor_stream

Downstream consumer of the RC4 keystream generator. Fetches keystream bytes over the generator's `key_valid`/`nxt_key` handshake, buffers them in a small prefetch FIFO to hide the multi-cycle generation latency, and XORs them byte-for-byte with a valid/ready plaintext stream to produce a valid/ready ciphertext stream (the same path decrypts). Optional RC4-drop[N] discards the first keystream bytes.

## Interface
- `KS_DEPTH`, 4, keystream FIFO depth; power of two, ≥2
- `DROP_N`, 256, keystream bytes discarded after reset (only with `RC4_DROP_EN`)
- `CNT_W`, 32, width of the processed-byte counter
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `ks_valid` in 1: generator `key_valid`
- `ks_data` in 8: generator `Dout`
- `ks_next` out 1: to generator `nxt_key`; one-cycle pulse per consumed byte
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in 8 / `in_last` in 1: plaintext stream
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out 8 / `out_last` out 1: ciphertext stream
- `byte_cnt` out CNT_W: bytes accepted since reset, wraps mod 2^CNT_W
- `ks_level` out $clog2(KS_DEPTH)+1: FIFO occupancy

## Operation
- Fetch FSM, states F_WAIT, F_BLANK:
  - F_WAIT: if `ks_valid` && FIFO not full → capture `ks_data`, register `ks_next`=1, go F_BLANK. Else stay.
  - F_BLANK: register `ks_next`=0; stay until `ks_valid`==0 sampled, then F_WAIT.
  - The generator holds `key_valid` high one cycle after seeing `nxt_key`; F_BLANK guarantees exactly one capture per pulse. Never capture in F_BLANK.
- Captured byte is pushed into FIFO unless dropped (see Configuration).
- `in_ready` = FIFO not empty && (!`out_valid` || `out_ready`), combinational.
- Accept (`in_valid`&&`in_ready`): `out_data`←`in_data` ^ FIFO head, `out_last`←`in_last`, `out_valid`←1, pop FIFO, `byte_cnt`+1.
- `out_ready`&&`out_valid` with no accept that cycle: `out_valid`←0.
- `out_valid`&&!`out_ready`: `out_data`/`out_last` held stable; `in_ready`=0.
- Simultaneous push and pop: occupancy unchanged; pop of the only entry while pushing is legal (head after pop is the new byte).
- `in_last` has no effect on keystream position; the stream continues across packets.
- All arithmetic 8-bit XOR; no carries. `byte_cnt` wraps silently.

## Timing
- Reset values: `ks_next`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `byte_cnt`=0, `ks_level`=0, FSM F_WAIT, FIFO empty, drop counter 0.
- Plaintext accept → `out_valid` next cycle (1-cycle latency); full throughput 1 byte/cycle while FIFO non-empty.
- Keystream capture: `ks_valid` sampled high in cycle t → `ks_next` high in t+1 only; next capture no earlier than generator re-assertion (~6 cycles/byte sustained).
- FIFO push visible to `in_ready` the cycle after capture.
- `rst` mid-operation: all state cleared on the next edge; any byte in flight is lost; generator is not rewound, so keystream resumes from its current position (and drop restarts).

## Configuration
- `RC4_DROP_EN` defined: a counter (width $clog2(DROP_N+1)) counts captures; while it is < `DROP_N`, captured bytes are handshaken (`ks_next` pulsed) but not pushed. After `DROP_N` captures, normal pushing.
- Not defined: drop logic absent, `DROP_N` ignored, every captured byte is pushed.

## Structure
- Package `rc4_pkg`: fetch-state enum (F_WAIT, F_BLANK), `byte_t` 8-bit typedef, shared default constants for `KS_DEPTH`/`DROP_N`.
- Sub-module `rc4_ks_fifo`: synchronous FIFO (push, pop, head, full, empty, level), show-ahead head output; instantiated once.

## Test plan
- Keystream 0xA5, 0x3C preloaded; plaintext 0xFF, 0x00 → `out_data` 0x5A, 0x3C, `byte_cnt`=2.
- Stub generator holding `ks_valid` one extra cycle after `ks_next` → exactly one push per pulse, `ks_next` never high two consecutive cycles.
- `out_ready`=0 for 5 cycles with `out_valid`=1 → `out_data` stable, `in_ready`=0, no pop; release → transfer resumes, no byte lost/duplicated.
- `KS_DEPTH`=4, no plaintext → after 4 captures `ks_level`=4, no further `ks_next` while `ks_valid` high.
- `RC4_DROP_EN`, `DROP_N`=3, keystream 0x01..0x05, plaintext 0x00 → first `out_data`=0x04, 5 `ks_next` pulses total.
- Pulse `rst` with FIFO at 2 and `out_valid`=1 → next cycle `out_valid`=0, `ks_level`=0, `byte_cnt`=0, `ks_next`=0, FSM F_WAIT.
